// File: rtl/fft_frame_loader_pkg.sv
// Shared definitions for the ADC-to-FFT frame loader: defaults, complex word
// layout, reader state encoding and the bit-reversal helper.
package fft_frame_loader_pkg;

   localparam int unsigned DEF_DATA_W       = 12;
   localparam int unsigned DEF_FFT_LEN_LOG2 = 4;
   localparam int unsigned MAX_LEN_LOG2     = 10;

   // Complex word layout: half index of re and im within {upper, lower}.
   localparam int unsigned CPLX_RE_HALF = 1;
   localparam int unsigned CPLX_IM_HALF = 0;

   typedef enum logic {
      StIdle,
      StDrain
   } rd_state_e;

   // Reverse the low n bits of idx; bits at and above n must be zero.
   function automatic logic [MAX_LEN_LOG2-1:0] bitrev(input logic [MAX_LEN_LOG2-1:0] idx,
                                                     input int unsigned n);
      logic [MAX_LEN_LOG2-1:0] full;
      full = {<<{idx}};
      return full >> (MAX_LEN_LOG2 - n);
   endfunction

endpackage

// File: rtl/fft_frame_loader_frame_bank_ram.sv
// Two-bank frame store: one synchronous write port, one asynchronous read port.
// The bank select is the MSB of each address.
module fft_frame_loader_frame_bank_ram #(
   parameter int unsigned DATA_W = 12,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [2**ADDR_W];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fft_frame_loader.sv
// Assembles conditioned ADC samples into ping-pong frames and streams each full
// frame to the FFT core in bit-reversed or natural order, counting overrun drops.
module fft_frame_loader
   import fft_frame_loader_pkg::*;
#(
   parameter int unsigned DATA_W       = DEF_DATA_W,
   parameter int unsigned FFT_LEN_LOG2 = DEF_FFT_LEN_LOG2,
   parameter bit          BIT_REVERSE  = 1'b1,
   parameter bit          OFFSET_BIN   = 1'b1,
   parameter int unsigned SHIFT        = 1,
   parameter int unsigned DROP_W       = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                flush,
   input  logic                s_valid,
   input  logic [DATA_W-1:0]   s_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [2*DATA_W-1:0] m_data,
   output logic                m_sof,
   output logic                m_eof,
   output logic                drop_pulse,
   output logic [DROP_W-1:0]   drop_cnt
);

   localparam int unsigned AW = FFT_LEN_LOG2;
   localparam logic [AW-1:0] LAST_IDX = '1;

   logic [DATA_W-1:0]   w_x;
   logic [DATA_W-1:0]   w_re;
   logic [DATA_W-1:0]   w_rd_data;
   logic [AW-1:0]       w_rd_addr;

   rd_state_e           r_state, w_state_d;
   logic                r_wr_bank, w_wr_bank_d;
   logic                r_rd_bank, w_rd_bank_d;
   logic [AW-1:0]       r_wr_idx, w_wr_idx_d;
   logic [AW-1:0]       r_rd_idx, w_rd_idx_d;
   logic [1:0]          r_bank_full, w_bank_full_d;
   logic [1:0]          w_set, w_clr;
   logic                r_m_valid, w_m_valid_d;
   logic                r_m_sof, w_m_sof_d;
   logic                r_m_eof, w_m_eof_d;
   logic [2*DATA_W-1:0] r_m_data, w_m_data_d;
   logic                r_drop_pulse;
   logic [DROP_W-1:0]   r_drop_cnt, w_drop_cnt_d;
   logic                w_wr_en, w_drop, w_slot_free;

   assign w_x  = s_data ^ {OFFSET_BIN, {(DATA_W-1){1'b0}}};
   assign w_re = $signed(w_x) >>> SHIFT;

   // A sample coinciding with flush is discarded without counting as a drop.
   assign w_wr_en     = s_valid & ~flush & ~r_bank_full[r_wr_bank];
   assign w_drop      = s_valid & ~flush &  r_bank_full[r_wr_bank];
   assign w_slot_free = ~r_m_valid | m_ready;
   assign w_rd_addr   = BIT_REVERSE ? AW'(bitrev(MAX_LEN_LOG2'(r_rd_idx), AW)) : r_rd_idx;

   fft_frame_loader_frame_bank_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (AW + 1)
   ) u_frame_bank_ram (
      .i_clk   (clk),
      .i_we    (w_wr_en),
      .i_waddr ({r_wr_bank, r_wr_idx}),
      .i_wdata (w_re),
      .i_raddr ({r_rd_bank, w_rd_addr}),
      .o_rdata (w_rd_data)
   );

   always_comb begin
      w_wr_idx_d   = r_wr_idx;
      w_wr_bank_d  = r_wr_bank;
      w_set        = '0;
      w_drop_cnt_d = r_drop_cnt;
      if (w_wr_en) begin
         w_wr_idx_d = r_wr_idx + 1'b1;
         if (r_wr_idx == LAST_IDX) begin
            w_set[r_wr_bank] = 1'b1;
            w_wr_bank_d      = ~r_wr_bank;
         end
      end
      if (w_drop && (r_drop_cnt != '1)) begin
         w_drop_cnt_d = r_drop_cnt + 1'b1;
      end
      if (flush) begin
         w_wr_idx_d  = '0;
         w_wr_bank_d = 1'b0;
      end
   end

   always_comb begin
      w_state_d   = r_state;
      w_rd_idx_d  = r_rd_idx;
      w_rd_bank_d = r_rd_bank;
      w_clr       = '0;
      w_m_valid_d = r_m_valid;
      w_m_data_d  = r_m_data;
      w_m_sof_d   = r_m_sof;
      w_m_eof_d   = r_m_eof;
      unique case (r_state)
         StIdle: begin
            if (m_ready) begin
               w_m_valid_d = 1'b0;
            end
            if (r_bank_full[r_rd_bank]) begin
               w_rd_idx_d = '0;
               w_state_d  = StDrain;
            end
         end
         StDrain: begin
            if (w_slot_free) begin
               w_m_valid_d = 1'b1;
               w_m_data_d[CPLX_RE_HALF*DATA_W +: DATA_W] = w_rd_data;
               w_m_data_d[CPLX_IM_HALF*DATA_W +: DATA_W] = '0;
               w_m_sof_d   = (r_rd_idx == '0);
               w_m_eof_d   = (r_rd_idx == LAST_IDX);
               w_rd_idx_d  = r_rd_idx + 1'b1;
               if (r_rd_idx == LAST_IDX) begin
                  w_clr[r_rd_bank] = 1'b1;
                  w_rd_bank_d      = ~r_rd_bank;
                  w_state_d        = StIdle;
               end
            end
         end
         default: w_state_d = StIdle;
      endcase
      if (flush) begin
         w_state_d   = StIdle;
         w_rd_idx_d  = '0;
         w_rd_bank_d = 1'b0;
         w_m_valid_d = 1'b0;
         w_m_sof_d   = 1'b0;
         w_m_eof_d   = 1'b0;
      end
   end

   // Writer and reader never target the same bank, so set and clear compose freely.
   always_comb begin
      w_bank_full_d = (r_bank_full | w_set) & ~w_clr;
      if (flush) begin
         w_bank_full_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= StIdle;
         r_wr_bank    <= 1'b0;
         r_rd_bank    <= 1'b0;
         r_wr_idx     <= '0;
         r_rd_idx     <= '0;
         r_bank_full  <= '0;
         r_m_valid    <= 1'b0;
         r_m_data     <= '0;
         r_m_sof      <= 1'b0;
         r_m_eof      <= 1'b0;
         r_drop_pulse <= 1'b0;
         r_drop_cnt   <= '0;
      end else begin
         r_state      <= w_state_d;
         r_wr_bank    <= w_wr_bank_d;
         r_rd_bank    <= w_rd_bank_d;
         r_wr_idx     <= w_wr_idx_d;
         r_rd_idx     <= w_rd_idx_d;
         r_bank_full  <= w_bank_full_d;
         r_m_valid    <= w_m_valid_d;
         r_m_data     <= w_m_data_d;
         r_m_sof      <= w_m_sof_d;
         r_m_eof      <= w_m_eof_d;
         r_drop_pulse <= w_drop;
         r_drop_cnt   <= w_drop_cnt_d;
      end
   end

   assign m_valid    = r_m_valid;
   assign m_data     = r_m_data;
   assign m_sof      = r_m_sof;
   assign m_eof      = r_m_eof;
   assign drop_pulse = r_drop_pulse;
   assign drop_cnt   = r_drop_cnt;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench: instance A (LEN=16, bit-reversed, raw binary, no shift) and
// instance B (LEN=4, natural order, offset binary, shift 1).
module tb_fft_frame_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        flush_a, s_valid_a, m_ready_a;
   logic [11:0] s_data_a;
   logic        a_m_valid, a_m_sof, a_m_eof, a_drop_pulse;
   logic [23:0] a_m_data;
   logic [15:0] a_drop_cnt;

   logic        flush_b, s_valid_b, m_ready_b;
   logic [11:0] s_data_b;
   logic        b_m_valid, b_m_sof, b_m_eof, b_drop_pulse;
   logic [23:0] b_m_data;
   logic [15:0] b_drop_cnt;

   fft_frame_loader #(
      .DATA_W       (12),
      .FFT_LEN_LOG2 (4),
      .BIT_REVERSE  (1'b1),
      .OFFSET_BIN   (1'b0),
      .SHIFT        (0),
      .DROP_W       (16)
   ) u_dut_a (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush_a),
      .s_valid    (s_valid_a),
      .s_data     (s_data_a),
      .m_valid    (a_m_valid),
      .m_ready    (m_ready_a),
      .m_data     (a_m_data),
      .m_sof      (a_m_sof),
      .m_eof      (a_m_eof),
      .drop_pulse (a_drop_pulse),
      .drop_cnt   (a_drop_cnt)
   );

   fft_frame_loader #(
      .DATA_W       (12),
      .FFT_LEN_LOG2 (2),
      .BIT_REVERSE  (1'b0),
      .OFFSET_BIN   (1'b1),
      .SHIFT        (1),
      .DROP_W       (16)
   ) u_dut_b (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush_b),
      .s_valid    (s_valid_b),
      .s_data     (s_data_b),
      .m_valid    (b_m_valid),
      .m_ready    (m_ready_b),
      .m_data     (b_m_data),
      .m_sof      (b_m_sof),
      .m_eof      (b_m_eof),
      .drop_pulse (b_drop_pulse),
      .drop_cnt   (b_drop_cnt)
   );

   typedef struct packed {
      logic        sof;
      logic        eof;
      logic [23:0] data;
      logic [31:0] cyc;
   } word_t;

   word_t       qa[$];
   word_t       qb[$];
   int          rd_a = 0;
   int          rd_b = 0;
   int unsigned cyc = 0;
   int          drop_seen_a = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   int br16[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
   logic [11:0] in_b[8] = '{12'h800, 12'hFFF, 12'h000, 12'h805,
                            12'h80A, 12'h80C, 12'h80E, 12'h810};
   logic [11:0] re_b[8] = '{12'h000, 12'h3FF, 12'hC00, 12'h002,
                            12'h005, 12'h006, 12'h007, 12'h008};

   always @(posedge clk) cyc <= cyc + 1;

   // Words are captured where they will be accepted at the next rising edge.
   always @(negedge clk) begin
      if (a_m_valid && m_ready_a) qa.push_back({a_m_sof, a_m_eof, a_m_data, cyc});
      if (b_m_valid && m_ready_b) qb.push_back({b_m_sof, b_m_eof, b_m_data, cyc});
      if (a_drop_pulse) drop_seen_a++;
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_a(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         s_valid_a = 1'b1;
         s_data_a  = 12'(base + i);
         step();
      end
      s_valid_a = 1'b0;
   endtask

   task automatic wait_a(input int n, input int budget);
      int k = 0;
      while (((qa.size() - rd_a) < n) && (k < budget)) begin
         step();
         k++;
      end
   endtask

   task automatic check_frame_a(input string tag, input int base, input bit contiguous);
      int          avail;
      logic [11:0] re;
      avail = qa.size() - rd_a;
      check_eq({tag, ".avail"}, 32'((avail >= 16) ? 1 : 0), 32'd1);
      if (avail >= 16) begin
         for (int i = 0; i < 16; i++) begin
            re = 12'(base + br16[i]);
            check_eq($sformatf("%s.data[%0d]", tag, i), 32'(qa[rd_a+i].data), 32'({re, 12'h000}));
            check_eq($sformatf("%s.flags[%0d]", tag, i),
                     32'({qa[rd_a+i].sof, qa[rd_a+i].eof}), 32'({i == 0, i == 15}));
         end
         if (contiguous) begin
            check_eq({tag, ".span"}, qa[rd_a+15].cyc - qa[rd_a].cyc, 32'd15);
         end
         rd_a += 16;
      end
   endtask

   initial begin
      logic [23:0] held;
      int          d0;
      reset_n   = 1'b0;
      flush_a   = 1'b0;
      s_valid_a = 1'b0;
      s_data_a  = '0;
      m_ready_a = 1'b1;
      flush_b   = 1'b0;
      s_valid_b = 1'b0;
      s_data_b  = '0;
      m_ready_b = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst.m_valid", 32'(a_m_valid), 32'd0);
      check_eq("rst.m_data", 32'(a_m_data), 32'd0);
      check_eq("rst.sof_eof", 32'({a_m_sof, a_m_eof}), 32'd0);
      check_eq("rst.drop_pulse", 32'(a_drop_pulse), 32'd0);
      check_eq("rst.drop_cnt", 32'(a_drop_cnt), 32'd0);
      check_eq("rst.b_valid", 32'(b_m_valid), 32'd0);
      reset_n = 1'b1;
      step();

      // Ramp with latency: last write at edge N, first word valid after N+2.
      send_a(0, 16);
      check_eq("lat.n0", 32'(a_m_valid), 32'd0);
      step();
      check_eq("lat.n1", 32'(a_m_valid), 32'd0);
      step();
      check_eq("lat.n2.valid", 32'(a_m_valid), 32'd1);
      check_eq("lat.n2.sof", 32'(a_m_sof), 32'd1);
      check_eq("lat.n2.data", 32'(a_m_data), 32'd0);
      wait_a(16, 40);
      check_frame_a("ramp", 0, 1'b1);

      // Backpressure mid-frame.
      send_a(100, 16);
      wait_a(4, 60);
      m_ready_a = 1'b0;
      held = a_m_data;
      for (int i = 0; i < 5; i++) begin
         step();
         check_eq($sformatf("bp.hold_valid[%0d]", i), 32'(a_m_valid), 32'd1);
         check_eq($sformatf("bp.hold_data[%0d]", i), 32'(a_m_data), 32'(held));
      end
      m_ready_a = 1'b1;
      wait_a(16, 60);
      check_frame_a("bp", 100, 1'b0);
      repeat (3) step();
      check_eq("bp.extra", 32'(qa.size() - rd_a), 32'd0);

      // Overrun: 40 samples with the sink stalled.
      m_ready_a = 1'b0;
      d0 = drop_seen_a;
      send_a(200, 16);
      send_a(300, 16);
      send_a(400, 8);
      step();
      step();
      check_eq("ovr.pulses", 32'(drop_seen_a - d0), 32'd8);
      check_eq("ovr.drop_cnt", 32'(a_drop_cnt), 32'd8);
      check_eq("ovr.none_out", 32'(qa.size() - rd_a), 32'd0);
      m_ready_a = 1'b1;
      wait_a(32, 100);
      check_frame_a("ovr0", 200, 1'b0);
      check_frame_a("ovr1", 300, 1'b0);
      check_eq("ovr.drop_cnt_after", 32'(a_drop_cnt), 32'd8);

      // Flush after a partial frame, with a sample in the flush cycle.
      d0 = drop_seen_a;
      send_a(500, 8);
      flush_a   = 1'b1;
      s_valid_a = 1'b1;
      s_data_a  = 12'hABC;
      step();
      flush_a   = 1'b0;
      s_valid_a = 1'b0;
      check_eq("flush.m_valid", 32'(a_m_valid), 32'd0);
      check_eq("flush.drop_cnt", 32'(a_drop_cnt), 32'd8);
      send_a(600, 16);
      wait_a(16, 60);
      check_frame_a("flush", 600, 1'b1);
      repeat (3) step();
      check_eq("flush.extra", 32'(qa.size() - rd_a), 32'd0);
      check_eq("flush.no_drop", 32'(drop_seen_a - d0), 32'd0);

      // Reset after a partial frame.
      send_a(700, 8);
      reset_n = 1'b0;
      step();
      check_eq("rst2.drop_cnt", 32'(a_drop_cnt), 32'd0);
      check_eq("rst2.m_valid", 32'(a_m_valid), 32'd0);
      reset_n = 1'b1;
      step();
      send_a(800, 16);
      wait_a(16, 60);
      check_frame_a("rst2", 800, 1'b1);
      repeat (3) step();
      check_eq("rst2.extra", 32'(qa.size() - rd_a), 32'd0);

      // Instance B: conditioning frame then natural-order frame.
      for (int i = 0; i < 8; i++) begin
         s_valid_b = 1'b1;
         s_data_b  = in_b[i];
         step();
      end
      s_valid_b = 1'b0;
      begin
         int k = 0;
         while (((qb.size() - rd_b) < 8) && (k < 40)) begin
            step();
            k++;
         end
      end
      check_eq("b.avail", 32'(qb.size() - rd_b), 32'd8);
      if ((qb.size() - rd_b) >= 8) begin
         for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("b.data[%0d]", i), 32'(qb[rd_b+i].data), 32'({re_b[i], 12'h000}));
            check_eq($sformatf("b.flags[%0d]", i), 32'({qb[rd_b+i].sof, qb[rd_b+i].eof}),
                     32'({(i % 4) == 0, (i % 4) == 3}));
         end
         rd_b += 8;
      end
      check_eq("b.drop_cnt", 32'(b_drop_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
